// File: rtl/ps2_rx_decoder_if.sv
// Signal bundle between the PS/2 pins, the receiver and its consumers.
// Handshake: raw_valid, key_valid and frame_err are single-cycle valid-only pulses with no ready; the data they qualify holds until the next pulse.
interface ps2_rx_decoder_if;
    logic        ps2_clk;
    logic        ps2_data;
    logic [7:0]  raw_byte;
    logic        raw_valid;
    logic [7:0]  key_code;
    logic        key_ext;
    logic        key_break;
    logic        key_valid;
    logic        frame_err;
    logic [15:0] keycode;
    logic [1:0]  dbg_state;
    logic        dbg_parity_ok;

    modport master (
        input  ps2_clk, ps2_data,
        output raw_byte, raw_valid, key_code, key_ext, key_break, key_valid,
        output frame_err, keycode, dbg_state, dbg_parity_ok
    );

    modport slave (
        output ps2_clk, ps2_data,
        input  raw_byte, raw_valid, key_code, key_ext, key_break, key_valid,
        input  frame_err, keycode, dbg_state, dbg_parity_ok
    );
endinterface

// File: rtl/ps2_rx_decoder.sv
// Synchronous PS/2 keyboard receiver: synchroniser, glitch filter, frame FSM, timeout, E0/F0 prefix decode.
// Define PS2_RX_PARITY_CHECK_EN to reject frames whose parity is wrong; otherwise only the stop bit decides.
module ps2_rx_decoder #(
    parameter int FILTER_LEN     = 19,
    parameter int FILTER_WIDTH   = 5,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int TIMEOUT_WIDTH  = 17
) (
    input logic              clk,
    input logic              rst,
    ps2_rx_decoder_if.master bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    localparam logic [FILTER_WIDTH-1:0]  FILTER_TERM  = FILTER_WIDTH'(FILTER_LEN - 1);
    localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_TERM = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [1:0]              clk_sync;
    logic [1:0]              data_sync;
    logic [1:0]              sync_s;
    logic [1:0]              filt;
    logic [FILTER_WIDTH-1:0] fcnt [2];
    logic                    filt_clk_q;
    logic                    sample;
    logic                    data_f;

    state_t                   state, state_nxt;
    logic [2:0]               bit_cnt, bit_cnt_nxt;
    logic [7:0]               shreg, shreg_nxt;
    logic                     parity_bit, parity_nxt;
    logic [TIMEOUT_WIDTH-1:0] tcnt, tcnt_nxt;
    logic                     accept;
    logic                     reject;
    logic                     timeout;
    logic                     parity_good;
    logic                     parity_ok;

    logic [7:0]  raw_byte_q;
    logic        raw_valid_q;
    logic [7:0]  key_code_q;
    logic        key_ext_q;
    logic        key_break_q;
    logic        key_valid_q;
    logic        frame_err_q;
    logic [15:0] keycode_q;
    logic        ext_flag;
    logic        brk_flag;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], bus.ps2_clk};
            data_sync <= {data_sync[0], bus.ps2_data};
        end
    end

    // Index 0 is the clock line, index 1 the data line.
    assign sync_s = {data_sync[1], clk_sync[1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            filt <= 2'b11;
            fcnt <= '{default: '0};
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync_s[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FILTER_TERM) begin
                    filt[i] <= sync_s[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + FILTER_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            filt_clk_q <= 1'b1;
        end else begin
            filt_clk_q <= filt[0];
        end
    end

    assign sample = filt_clk_q & ~filt[0];
    assign data_f = filt[1];

    // Odd parity: the nine bits together must contain an odd number of ones.
    assign parity_good = ^{shreg, parity_bit};

`ifdef PS2_RX_PARITY_CHECK_EN
    assign parity_ok = parity_good;
`else
    assign parity_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            parity_bit <= 1'b0;
            tcnt       <= '0;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= bit_cnt_nxt;
            shreg      <= shreg_nxt;
            parity_bit <= parity_nxt;
            tcnt       <= tcnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        parity_nxt  = parity_bit;
        tcnt_nxt    = tcnt;
        accept      = 1'b0;
        reject      = 1'b0;
        timeout     = 1'b0;

        unique case (state)
            IDLE: begin
                if (sample && !data_f) begin
                    state_nxt   = DATA;
                    bit_cnt_nxt = '0;
                end
            end
            DATA: begin
                if (sample) begin
                    shreg_nxt[bit_cnt] = data_f;
                    bit_cnt_nxt        = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_nxt = PARITY;
                    end
                end
            end
            PARITY: begin
                if (sample) begin
                    parity_nxt = data_f;
                    state_nxt  = STOP;
                end
            end
            STOP: begin
                if (sample) begin
                    if (data_f && parity_ok) begin
                        accept = 1'b1;
                    end else begin
                        reject = 1'b1;
                    end
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A sample arriving on the terminal count takes precedence over the abort.
        if (state == IDLE) begin
            tcnt_nxt = '0;
        end else if (sample) begin
            tcnt_nxt = '0;
        end else if (tcnt == TIMEOUT_TERM) begin
            timeout   = 1'b1;
            state_nxt = IDLE;
            tcnt_nxt  = '0;
        end else begin
            tcnt_nxt = tcnt + TIMEOUT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            raw_byte_q  <= '0;
            raw_valid_q <= 1'b0;
            key_code_q  <= '0;
            key_ext_q   <= 1'b0;
            key_break_q <= 1'b0;
            key_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            keycode_q   <= '0;
            ext_flag    <= 1'b0;
            brk_flag    <= 1'b0;
        end else begin
            raw_valid_q <= accept;
            key_valid_q <= 1'b0;
            frame_err_q <= reject | timeout;
            if (accept) begin
                raw_byte_q <= shreg;
                keycode_q  <= {keycode_q[7:0], shreg};
                if (shreg == 8'hE0) begin
                    ext_flag <= 1'b1;
                end else if (shreg == 8'hF0) begin
                    brk_flag <= 1'b1;
                end else begin
                    key_code_q  <= shreg;
                    key_ext_q   <= ext_flag;
                    key_break_q <= brk_flag;
                    key_valid_q <= 1'b1;
                    ext_flag    <= 1'b0;
                    brk_flag    <= 1'b0;
                end
            end else if (reject || timeout) begin
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
            end
        end
    end

    assign bus.raw_byte      = raw_byte_q;
    assign bus.raw_valid     = raw_valid_q;
    assign bus.key_code      = key_code_q;
    assign bus.key_ext       = key_ext_q;
    assign bus.key_break     = key_break_q;
    assign bus.key_valid     = key_valid_q;
    assign bus.frame_err     = frame_err_q;
    assign bus.keycode       = keycode_q;
    assign bus.dbg_state     = state;
    assign bus.dbg_parity_ok = parity_good;

endmodule
